// File: rtl/rom_pipe_pkg.sv
// rom_pkg: shared constants and helpers for the pipelined ROM
// Contents: clog2, LEAF_ADDR_W (address bits resolved inside one LUT bank),
//           leaf_count (number of 16-word LUT banks for a given depth)
package rom_pkg;

   localparam int LEAF_ADDR_W = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) if ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int leaf_count(input int depth);
      return depth >> LEAF_ADDR_W;
   endfunction

endpackage

// File: rtl/rom_pipe_leaf16.sv
// rom_leaf16: combinational 16-word LUT bank, one LUT4 per data bit
// Ports: ADDR  word select within the bank
//        DATA  selected word; bit b of word w is INIT16[w*WIDTH+b]
module rom_leaf16
   import rom_pkg::*;
#(
   parameter int                  WIDTH  = 8,
   parameter logic [16*WIDTH-1:0] INIT16 = '0
) (
   input  logic [LEAF_ADDR_W-1:0] ADDR,
   output logic [WIDTH-1:0]       DATA
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [15:0] t;
      for (genvar w = 0; w < 16; w++) begin : g_w
         assign t[w] = INIT16[w*WIDTH+b];
      end
      assign DATA[b] = t[ADDR];
   end

endmodule

// File: rtl/rom_pipe.sv
// rom_pipe: pipelined ROM with valid/ready handshake, contents fixed by INIT
// Ports: CLK/RESET (async, active-high); I_ADDR/I_VALID/I_READY address in;
//        O_DATA/O_ADDR/O_VALID/O_READY word out with its source address.
// Build option ROM_PIPE_EN: register the leaf words between the LUT banks and
//        the mux tree (latency 2); without it the read is 1 cycle.
module rom_pipe
   import rom_pkg::*;
#(
   parameter int                       WIDTH  = 8,
   parameter int                       DEPTH  = 256,
   parameter logic [DEPTH*WIDTH-1:0]   INIT   = '0,
   localparam int                      ADDR_W = clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] I_ADDR,
   input  logic              I_VALID,
   output logic              I_READY,
   output logic [WIDTH-1:0]  O_DATA,
   output logic [ADDR_W-1:0] O_ADDR,
   output logic              O_VALID,
   input  logic              O_READY
);

   localparam int L  = leaf_count(DEPTH);
   localparam int U  = ADDR_W - LEAF_ADDR_W;
   localparam int UW = U > 0 ? U : 1;

   logic              stall;
   logic [L*WIDTH-1:0] leaf_c, leaf_s;
   logic [ADDR_W-1:0]  addr_s;
   logic               valid_s;
   logic [UW-1:0]      hi;
   logic [WIDTH-1:0]   node [0:2*L-2];

   // one stall signal freezes every stage, so bubbles are kept, never squeezed
   assign stall   = O_VALID && !O_READY;
   assign I_READY = !stall;

   for (genvar i = 0; i < L; i++) begin : g_leaf
      rom_leaf16 #(.WIDTH(WIDTH), .INIT16(INIT[i*16*WIDTH +: 16*WIDTH])) u_leaf (
         .ADDR(I_ADDR[LEAF_ADDR_W-1:0]),
         .DATA(leaf_c[i*WIDTH +: WIDTH])
      );
   end

`ifdef ROM_PIPE_EN
   logic [L*WIDTH-1:0] leaf_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               valid_q;
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         leaf_q  <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         leaf_q  <= leaf_c;
         addr_q  <= I_ADDR;
         valid_q <= I_VALID;
      end
   assign leaf_s  = leaf_q;
   assign addr_s  = addr_q;
   assign valid_s = valid_q;
`else
   assign leaf_s  = leaf_c;
   assign addr_s  = I_ADDR;
   assign valid_s = I_VALID;
`endif

   // heap-ordered 2:1 tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1),
   // leaves sit at L-1.., and a node at depth d selects on upper bit U-1-d
   assign hi = UW'(addr_s >> LEAF_ADDR_W);

   for (genvar i = 0; i < L; i++) begin : g_tleaf
      assign node[L-1+i] = leaf_s[i*WIDTH +: WIDTH];
   end

   for (genvar n = 0; n < L - 1; n++) begin : g_mux
      localparam int DP = clog2(n + 2) - 1;
      assign node[n] = hi[U-1-DP] ? node[2*n+2] : node[2*n+1];
   end

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         O_VALID <= 1'b0;
         O_DATA  <= '0;
         O_ADDR  <= '0;
      end else if (!stall) begin
         O_VALID <= valid_s;
         O_DATA  <= node[0];
         O_ADDR  <= addr_s;
      end

endmodule

// File: tb/tb_rom_pipe.sv
// tb_rom_pipe: self-checking bench for rom_pipe (WIDTH=8, DEPTH=256, word a = a^8'h5A)
module tb_rom_pipe;

   localparam int W = 8;
   localparam int D = 256;
`ifdef ROM_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   function automatic logic [D*W-1:0] mk_init();
      logic [D*W-1:0] r;
      for (int a = 0; a < D; a++) r[a*W +: W] = W'(a) ^ 8'h5A;
      return r;
   endfunction

   localparam logic [D*W-1:0] INIT_V = mk_init();

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] I_ADDR = 8'h00;
   logic       I_VALID = 1'b0;
   logic       I_READY;
   logic [7:0] O_DATA;
   logic [7:0] O_ADDR;
   logic       O_VALID;
   logic       O_READY = 1'b0;

   rom_pipe #(.WIDTH(W), .DEPTH(D), .INIT(INIT_V)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_ADDR(I_ADDR), .I_VALID(I_VALID), .I_READY(I_READY),
      .O_DATA(O_DATA), .O_ADDR(O_ADDR), .O_VALID(O_VALID), .O_READY(O_READY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } vec_t;

   int         tests = 0;
   int         fails = 0;
   int         out_cnt = 0;
   logic [7:0] q[$];
   logic       sb = 1'b0;
   logic       acc = 1'b0;
   logic       held = 1'b0;
   logic [7:0] hd, ha;
   logic [7:0] last_data;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   // one cycle: check held output, drive inputs, score the upcoming edge
   task automatic cyc(input logic v, input logic [7:0] a, input logic r);
      logic [7:0] e;
      @(negedge CLK);
      if (held) begin
         chk("hold_valid", 32'(O_VALID), 1);
         chk("hold_data", 32'(O_DATA), 32'(hd));
         chk("hold_addr", 32'(O_ADDR), 32'(ha));
      end
      I_VALID = v;
      I_ADDR  = a;
      O_READY = r;
      #1;
      acc = I_VALID && I_READY;
      if (sb && O_VALID && O_READY) begin
         if (q.size() == 0) chk("sb_spurious", 1, 0);
         else begin
            e = q.pop_front();
            chk("sb_addr", 32'(O_ADDR), 32'(e));
            chk("sb_data", 32'(O_DATA), 32'(e ^ 8'h5A));
            last_data = O_DATA;
            out_cnt++;
         end
      end
      if (sb && acc) q.push_back(a);
      held = O_VALID && !O_READY;
      hd   = O_DATA;
      ha   = O_ADDR;
   endtask

   task automatic rd1(input logic [7:0] a, input logic [7:0] exp);
      sb = 1'b0;
      cyc(1'b1, a, 1'b1);
      chk("rd_accept", 32'(acc), 1);
      for (int k = 1; k < LAT; k++) begin
         cyc(1'b0, 8'h00, 1'b1);
         chk("rd_early", 32'(O_VALID), 0);
      end
      cyc(1'b0, 8'h00, 1'b1);
      chk("rd_valid", 32'(O_VALID), 1);
      chk("rd_data", 32'(O_DATA), 32'(exp));
      chk("rd_addr", 32'(O_ADDR), 32'(a));
      cyc(1'b0, 8'h00, 1'b1);
      chk("rd_single", 32'(O_VALID), 0);
   endtask

   vec_t tbl[8];
   int   base, idx, n;

   initial begin
      tbl[0] = '{8'h00, 8'h5A};
      tbl[1] = '{8'hFF, 8'hA5};
      tbl[2] = '{8'h80, 8'hDA};
      tbl[3] = '{8'h10, 8'h4A};
      tbl[4] = '{8'h01, 8'h5B};
      tbl[5] = '{8'h5A, 8'h00};
      tbl[6] = '{8'hA5, 8'hFF};
      tbl[7] = '{8'h0F, 8'h55};

      #1;
      chk("rst_iready_during", 32'(I_READY), 1);
      chk("rst_valid_during", 32'(O_VALID), 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("rst_valid", 32'(O_VALID), 0);
      chk("rst_data", 32'(O_DATA), 0);
      chk("rst_addr", 32'(O_ADDR), 0);
      chk("rst_iready", 32'(I_READY), 1);

      for (int i = 0; i < 8; i++) rd1(tbl[i].addr, tbl[i].data);

      sb = 1'b1;
      base = out_cnt;
      for (int a = 0; a < 256; a++) begin
         cyc(1'b1, 8'(a), 1'b1);
         chk("sweep_acc", 32'(acc), 1);
      end
      repeat (LAT) cyc(1'b0, 8'h00, 1'b1);
      chk("sweep_count", 32'(out_cnt - base), 256);
      chk("sweep_empty", 32'(q.size()), 0);
      chk("sweep_last", 32'(last_data), 32'h A5);

      base = out_cnt;
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         cyc(1'b1, 8'(8'h10 + idx), !(c >= 3 && c < 7));
         if (c >= 3 && c < 7) chk("stall_iready", 32'(I_READY), 0);
         if (c == 3) chk("stall_valid", 32'(O_VALID), 1);
         if (acc) idx++;
      end
      repeat (LAT + 1) cyc(1'b0, 8'h00, 1'b1);
      chk("stall_count", 32'(out_cnt - base), 8);
      chk("stall_empty", 32'(q.size()), 0);

      base = out_cnt;
      n = 0;
      while (out_cnt - base < 10000 && n < 60000) begin
         cyc(1'($urandom), 8'($urandom), 1'($urandom));
         n++;
      end
      repeat (LAT + 1) cyc(1'b0, 8'h00, 1'b1);
      chk("rand_done", 32'(out_cnt - base >= 10000), 1);
      chk("rand_empty", 32'(q.size()), 0);

      cyc(1'b1, 8'h20, 1'b0);
      cyc(1'b1, 8'h21, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      chk("mid_pre_valid", 32'(O_VALID), 1);
      RESET = 1'b1;
      #1;
      chk("mid_valid_drop", 32'(O_VALID), 0);
      chk("mid_iready", 32'(I_READY), 1);
      q.delete();
      held = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < LAT + 2; k++) begin
         cyc(1'b0, 8'h00, 1'b1);
         chk("mid_no_ghost", 32'(O_VALID), 0);
      end
      rd1(8'h80, 8'hDA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
